// File: rtl/rename_nw.sv
// Register-rename stage: spec/retire RATs plus circular free list, WIDTH lanes in, COMMIT_W frees.
// Latency 1 (registered output); whole-group accept, stalls on output backpressure or too few free regs.
// Optional stall counters under RENAME_PERF_EN.
module rename_nw #(
  parameter int WIDTH       = 2,
  parameter int COMMIT_W    = 2,
  parameter int N_ARCH_REGS = 32,
  parameter int N_PHYS_REGS = 64,
  localparam int AREG_W   = $clog2(N_ARCH_REGS),
  localparam int PREG_W   = $clog2(N_PHYS_REGS),
  localparam int FL_DEPTH = N_PHYS_REGS - N_ARCH_REGS,
  localparam int CNT_W    = $clog2(FL_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH*AREG_W-1:0]    in_rs1_i,
  input  logic [WIDTH*AREG_W-1:0]    in_rs2_i,
  input  logic [WIDTH*AREG_W-1:0]    in_rd_i,
  input  logic [WIDTH-1:0]           in_rd_used_i,
  output logic [WIDTH-1:0]           out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH*PREG_W-1:0]    out_prs1_o,
  output logic [WIDTH*PREG_W-1:0]    out_prs2_o,
  output logic [WIDTH*PREG_W-1:0]    out_prd_o,
  output logic [WIDTH*PREG_W-1:0]    out_old_prd_o,
  output logic [WIDTH-1:0]           out_rd_used_o,
  input  logic [COMMIT_W-1:0]        commit_valid_i,
  input  logic [COMMIT_W-1:0]        commit_rd_used_i,
  input  logic [COMMIT_W*AREG_W-1:0] commit_rd_i,
  input  logic [COMMIT_W*PREG_W-1:0] commit_prd_i,
  input  logic [COMMIT_W*PREG_W-1:0] commit_old_prd_i,
  output logic [CNT_W-1:0]           fl_count_o,
  output logic [31:0]                perf_stall_fl_o,
  output logic [31:0]                perf_stall_bp_o
);
  localparam int FL_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  logic [PREG_W-1:0] spec_rat   [N_ARCH_REGS];
  logic [PREG_W-1:0] retire_rat [N_ARCH_REGS];
  logic [PREG_W-1:0] retire_nxt [N_ARCH_REGS];
  logic [PREG_W-1:0] fl         [FL_DEPTH];
  // retire_head would advance exactly like tail (one step per freed reg), so tail serves as both.
  logic [FL_W-1:0]   head, tail, tail_nxt;
  logic [CNT_W-1:0]  count, n_alloc, n_free;

  logic [WIDTH-1:0]  eff;
  logic [PREG_W-1:0] r_prd [WIDTH];
  logic [PREG_W-1:0] r_old [WIDTH];
  logic [PREG_W-1:0] r_ps1 [WIDTH];
  logic [PREG_W-1:0] r_ps2 [WIDTH];
  logic [COMMIT_W-1:0] ceff;
  logic [FL_W-1:0]     push_idx [COMMIT_W];
  logic out_busy, accept;

  function automatic logic [FL_W-1:0] fl_add(input logic [FL_W-1:0] p, input logic [CNT_W-1:0] n);
    logic [CNT_W:0] s;
    s = (CNT_W+1)'(p) + (CNT_W+1)'(n);
    if (s >= (CNT_W+1)'(FL_DEPTH)) s = s - (CNT_W+1)'(FL_DEPTH);
    return s[FL_W-1:0];
  endfunction

  // spec_rat[0] stays 0 forever (x0 is never written), so x0 sources need no special case.
  always_comb begin
    eff     = '0;
    n_alloc = '0;
    for (int j = 0; j < WIDTH; j++) begin
      r_prd[j] = '0;
      r_old[j] = '0;
      r_ps1[j] = '0;
      r_ps2[j] = '0;
      if (in_valid_i[j]) begin
        r_ps1[j] = spec_rat[in_rs1_i[j*AREG_W +: AREG_W]];
        r_ps2[j] = spec_rat[in_rs2_i[j*AREG_W +: AREG_W]];
        r_old[j] = spec_rat[in_rd_i[j*AREG_W +: AREG_W]];
        for (int i = 0; i < j; i++) begin
          if (eff[i]) begin
            if (in_rd_i[i*AREG_W +: AREG_W] == in_rs1_i[j*AREG_W +: AREG_W]) r_ps1[j] = r_prd[i];
            if (in_rd_i[i*AREG_W +: AREG_W] == in_rs2_i[j*AREG_W +: AREG_W]) r_ps2[j] = r_prd[i];
            if (in_rd_i[i*AREG_W +: AREG_W] == in_rd_i[j*AREG_W +: AREG_W])  r_old[j] = r_prd[i];
          end
        end
        if (in_rd_used_i[j] && in_rd_i[j*AREG_W +: AREG_W] != '0) begin
          eff[j]   = 1'b1;
          r_prd[j] = fl[fl_add(head, n_alloc)];
          n_alloc  = n_alloc + CNT_W'(1);
        end else begin
          r_old[j] = '0;
        end
      end
    end
  end

  always_comb begin
    retire_nxt = retire_rat;
    n_free     = '0;
    ceff       = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      push_idx[k] = fl_add(tail, n_free);
      if (commit_valid_i[k] && commit_rd_used_i[k] && commit_rd_i[k*AREG_W +: AREG_W] != '0) begin
        ceff[k] = 1'b1;
        retire_nxt[commit_rd_i[k*AREG_W +: AREG_W]] = commit_prd_i[k*PREG_W +: PREG_W];
        n_free = n_free + CNT_W'(1);
      end
    end
  end

  assign out_busy   = (|out_valid_o) && !out_ready_i;
  assign in_ready_o = !flush_i && !out_busy && (count >= n_alloc);
  assign accept     = (|in_valid_i) && in_ready_o;
  assign tail_nxt   = fl_add(tail, n_free);
  assign fl_count_o = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ARCH_REGS; i++) begin
        spec_rat[i]   <= PREG_W'(i);
        retire_rat[i] <= PREG_W'(i);
      end
      for (int s = 0; s < FL_DEPTH; s++) fl[s] <= PREG_W'(N_ARCH_REGS + s);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FL_DEPTH);
    end else begin
      retire_rat <= retire_nxt;
      tail       <= tail_nxt;
      for (int k = 0; k < COMMIT_W; k++)
        if (ceff[k]) fl[push_idx[k]] <= commit_old_prd_i[k*PREG_W +: PREG_W];
      if (flush_i) begin
        spec_rat <= retire_nxt;
        head     <= tail_nxt;
        count    <= CNT_W'(FL_DEPTH);
      end else begin
        if (accept) begin
          for (int j = 0; j < WIDTH; j++)
            if (eff[j]) spec_rat[in_rd_i[j*AREG_W +: AREG_W]] <= r_prd[j];
          head <= fl_add(head, n_alloc);
        end
        count <= count - (accept ? n_alloc : CNT_W'(0)) + n_free;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o   <= '0;
      out_rd_used_o <= '0;
      out_prs1_o    <= '0;
      out_prs2_o    <= '0;
      out_prd_o     <= '0;
      out_old_prd_o <= '0;
    end else if (!flush_i && accept) begin
      out_valid_o   <= in_valid_i;
      out_rd_used_o <= eff;
      for (int j = 0; j < WIDTH; j++) begin
        out_prs1_o[j*PREG_W +: PREG_W]    <= r_ps1[j];
        out_prs2_o[j*PREG_W +: PREG_W]    <= r_ps2[j];
        out_prd_o[j*PREG_W +: PREG_W]     <= r_prd[j];
        out_old_prd_o[j*PREG_W +: PREG_W] <= r_old[j];
      end
    end else if (flush_i || out_ready_i) begin
      out_valid_o   <= '0;
      out_rd_used_o <= '0;
      out_prs1_o    <= '0;
      out_prs2_o    <= '0;
      out_prd_o     <= '0;
      out_old_prd_o <= '0;
    end
  end

`ifdef RENAME_PERF_EN
  logic [31:0] stall_fl, stall_bp;
  logic        in_pending;
  assign in_pending = (|in_valid_i) && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_fl <= '0;
      stall_bp <= '0;
    end else begin
      if (in_pending && out_busy && stall_bp != '1) stall_bp <= stall_bp + 32'd1;
      if (in_pending && !out_busy && count < n_alloc && stall_fl != '1) stall_fl <= stall_fl + 32'd1;
    end
  end
  assign perf_stall_fl_o = stall_fl;
  assign perf_stall_bp_o = stall_bp;
`else
  assign perf_stall_fl_o = '0;
  assign perf_stall_bp_o = '0;
`endif
endmodule
